// File: rtl/bus_xfer_ctrl_pkg.sv
// Shared types and constants for the bus transfer controller and its decoder.
package bus_xfer_ctrl_pkg;

  localparam int BUS_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENABLE,
    S_SET,
    S_HOLD,
    S_DONE
  } state_t;

  // The ID one past the last register selects the immediate byte as source.
  function automatic int imm_id(input int num_regs);
    return num_regs;
  endfunction

endpackage

// File: rtl/bus_xfer_ctrl_decode.sv
// Turns a register ID plus a strobe into a one-hot-or-zero select vector.
module xfer_decode #(
  parameter int NUM_REGS = 4,
  parameter int IDW      = 3
) (
  input  logic [IDW-1:0]      id,
  input  logic                strobe,
  output logic [NUM_REGS-1:0] sel
);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sel[i] = strobe && (id == IDW'(i));
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Sequences one register-to-register or immediate-to-register bus transfer:
// source drive for three cycles, destination latch strobe in the middle one.
module bus_xfer_ctrl
  import bus_xfer_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int IDW      = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [IDW-1:0]      req_src,
  input  logic [IDW-1:0]      req_dst,
  input  logic [BUS_W-1:0]    req_imm,
  output logic [NUM_REGS-1:0] en,
  output logic [NUM_REGS-1:0] set,
  output logic [BUS_W-1:0]    bus_out,
  output logic                done,
  output logic                err
);

  state_t              state_q, state_d;
  logic [IDW-1:0]      src_q, src_d;
  logic [IDW-1:0]      dst_q, dst_d;
  logic [BUS_W-1:0]    imm_q, imm_d;
  logic [NUM_REGS-1:0] en_q, en_d;
  logic [NUM_REGS-1:0] set_q, set_d;
  logic [BUS_W-1:0]    bus_q, bus_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;

  logic accept, bad_req, drive, src_is_imm, en_strb, set_strb;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    imm_d   = imm_q;
    err_d   = 1'b0;
    accept  = req_valid && ready_q;
    bad_req = (int'(req_dst) >= NUM_REGS) ||
              (int'(req_src) > imm_id(NUM_REGS)) ||
              (req_src == req_dst);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bad_req) begin
            err_d = 1'b1;
          end else begin
            src_d   = req_src;
            dst_d   = req_dst;
            imm_d   = req_imm;
            state_d = S_ENABLE;
          end
        end
      end
      S_ENABLE: state_d = S_SET;
      S_SET:    state_d = S_HOLD;
      S_HOLD:   state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they land in the flops
    // together with it and never depend combinationally on the inputs.
    drive      = (state_d == S_ENABLE) || (state_d == S_SET) || (state_d == S_HOLD);
    src_is_imm = (int'(src_d) == imm_id(NUM_REGS));
    en_strb    = drive && !src_is_imm;
    set_strb   = (state_d == S_SET);
    bus_d      = (drive && src_is_imm) ? imm_d : '0;
    done_d     = (state_d == S_DONE);
    ready_d    = (state_d == S_IDLE);
  end

  xfer_decode #(.NUM_REGS(NUM_REGS), .IDW(IDW)) u_en_dec (
    .id     (src_d),
    .strobe (en_strb),
    .sel    (en_d)
  );

  xfer_decode #(.NUM_REGS(NUM_REGS), .IDW(IDW)) u_set_dec (
    .id     (dst_d),
    .strobe (set_strb),
    .sel    (set_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      imm_q   <= '0;
      en_q    <= '0;
      set_q   <= '0;
      bus_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      imm_q   <= imm_d;
      en_q    <= en_d;
      set_q   <= set_d;
      bus_q   <= bus_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign req_ready = ready_q;
  assign en        = en_q;
  assign set       = set_q;
  assign bus_out   = bus_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed table-driven bench for bus_xfer_ctrl plus reset-abort and back-to-back sequences.
module tb_bus_xfer_ctrl;

  localparam int NUM_REGS = 4;
  localparam int IDW      = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                req_valid;
  logic                req_ready;
  logic [IDW-1:0]      req_src;
  logic [IDW-1:0]      req_dst;
  logic [7:0]          req_imm;
  logic [NUM_REGS-1:0] en;
  logic [NUM_REGS-1:0] set;
  logic [7:0]          bus_out;
  logic                done;
  logic                err;

  int checks = 0;
  int errors = 0;

  bus_xfer_ctrl #(.NUM_REGS(NUM_REGS), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src   (req_src),
    .req_dst   (req_dst),
    .req_imm   (req_imm),
    .en        (en),
    .set       (set),
    .bus_out   (bus_out),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0]      src;
    logic [IDW-1:0]      dst;
    logic [7:0]          imm;
    logic                bad;
    logic [NUM_REGS-1:0] exp_en;
    logic [NUM_REGS-1:0] exp_set;
    logic [7:0]          exp_bus;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_en"}, 32'(en), 32'h0);
    check({tag, "_set"}, 32'(set), 32'h0);
    check({tag, "_bus"}, 32'(bus_out), 32'h0);
  endtask

  // Called just after a falling edge; issues one request and checks every
  // following cycle until the block is ready again.
  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    req_valid = 1'b1;
    req_src   = v.src;
    req_dst   = v.dst;
    req_imm   = v.imm;
    check({tag, "_ready_before"}, 32'(req_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_src   = 3'd3;
    req_dst   = 3'd3;
    req_imm   = 8'hFF;
    if (v.bad) begin
      check({tag, "_err"}, 32'(err), 32'h1);
      check({tag, "_ready_err"}, 32'(req_ready), 32'h1);
      check_idle_outputs({tag, "_c1"});
      @(negedge clk);
      check({tag, "_err_clear"}, 32'(err), 32'h0);
      check_idle_outputs({tag, "_c2"});
    end else begin
      for (int k = 1; k <= 3; k++) begin
        check($sformatf("%s_en_c%0d", tag, k), 32'(en), 32'(v.exp_en));
        check($sformatf("%s_bus_c%0d", tag, k), 32'(bus_out), 32'(v.exp_bus));
        check($sformatf("%s_set_c%0d", tag, k), 32'(set), (k == 2) ? 32'(v.exp_set) : 32'h0);
        check($sformatf("%s_done_c%0d", tag, k), 32'(done), 32'h0);
        check($sformatf("%s_ready_c%0d", tag, k), 32'(req_ready), 32'h0);
        @(negedge clk);
      end
      check({tag, "_done"}, 32'(done), 32'h1);
      check_idle_outputs({tag, "_c4"});
      @(negedge clk);
      check({tag, "_done_clear"}, 32'(done), 32'h0);
      check({tag, "_ready_after"}, 32'(req_ready), 32'h1);
    end
  endtask

  initial begin
    logic [NUM_REGS-1:0] prev_en, prev_set;
    int acc_cyc[3];
    int n_acc;
    bit dropping;

    vecs[0] = '{3'd1, 3'd2, 8'h00, 1'b0, 4'b0010, 4'b0100, 8'h00};
    vecs[1] = '{3'd4, 3'd0, 8'hA5, 1'b0, 4'b0000, 4'b0001, 8'hA5};
    vecs[2] = '{3'd3, 3'd3, 8'h00, 1'b1, 4'b0000, 4'b0000, 8'h00};
    vecs[3] = '{3'd0, 3'd5, 8'h00, 1'b1, 4'b0000, 4'b0000, 8'h00};
    vecs[4] = '{3'd6, 3'd1, 8'h00, 1'b1, 4'b0000, 4'b0000, 8'h00};
    vecs[5] = '{3'd2, 3'd3, 8'h11, 1'b0, 4'b0100, 4'b1000, 8'h00};
    vecs[6] = '{3'd4, 3'd3, 8'h3C, 1'b0, 4'b0000, 4'b1000, 8'h3C};
    vecs[7] = '{3'd3, 3'd0, 8'h00, 1'b0, 4'b1000, 4'b0001, 8'h00};
    vecs[8] = '{3'd4, 3'd4, 8'h77, 1'b1, 4'b0000, 4'b0000, 8'h00};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_src   = '0;
    req_dst   = '0;
    req_imm   = '0;
    #2;
    check_idle_outputs("rst");
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready", 32'(req_ready), 32'h1);

    // First request goes in on the very first rising edge after release.
    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset during the SET cycle aborts the transfer.
    req_valid = 1'b1;
    req_src   = 3'd0;
    req_dst   = 3'd1;
    req_imm   = 8'h00;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_en_enable", 32'(en), 32'h1);
    @(negedge clk);
    check("abort_set_set", 32'(set), 32'h2);
    #1 rst_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    check("abort_done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("abort_post_done_%0d", k), 32'(done), 32'h0);
      check($sformatf("abort_post_set_%0d", k), 32'(set), 32'h0);
      check($sformatf("abort_post_ready_%0d", k), 32'(req_ready), 32'h1);
      @(negedge clk);
    end

    // req_valid held high: three back-to-back transfers.
    req_valid = 1'b1;
    req_src   = 3'd1;
    req_dst   = 3'd0;
    n_acc     = 0;
    dropping  = 1'b0;
    prev_en   = '0;
    prev_set  = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (dropping) req_valid = 1'b0;
      check($sformatf("b2b_en_onehot_%0d", cyc), 32'($countones(en) <= 1), 32'h1);
      check($sformatf("b2b_set_onehot_%0d", cyc), 32'($countones(set) <= 1), 32'h1);
      check($sformatf("b2b_overlap_%0d", cyc), 32'(en & set), 32'h0);
      if (set != prev_set)
        check($sformatf("b2b_set_on_en_edge_%0d", cyc), 32'(en != prev_en), 32'h0);
      prev_en  = en;
      prev_set = set;
      if (req_valid && req_ready && n_acc < 3) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 3) dropping = 1'b1;
      end
      @(negedge clk);
    end
    check("b2b_accepts", 32'(n_acc), 32'd3);
    if (n_acc == 3) begin
      check("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd5);
      check("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd5);
    end
    check("b2b_idle_ready", 32'(req_ready), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
